// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron datapath blocks.
package neuron_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned WEIGHT_W    = 4;
    localparam int unsigned SCALE_SHIFT = 2;
    localparam int unsigned PROD_W      = DATA_W + WEIGHT_W;
    localparam int unsigned CNT_W       = 8;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StAct,
        StDone
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic              sat;
    } sat_sum_t;

    // Unsigned add that clamps at all-ones and flags the clamp.
    function automatic sat_sum_t sat_add(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b);
        logic [DATA_W:0] full;
        sat_sum_t        r;
        full    = {1'b0, a} + {1'b0, b};
        r.sat   = full[DATA_W];
        r.value = r.sat ? '1 : full[DATA_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/neuron_term.sv
// Synaptic term: weighted input scaled down by a fixed right shift, truncated to data width.
module neuron_term
    import neuron_pkg::*;
(
    input  logic [DATA_W-1:0]   in_data,
    input  logic [WEIGHT_W-1:0] in_weight,
    output logic [DATA_W-1:0]   term
);

    logic [PROD_W-1:0] prod;

    always_comb begin
        prod = PROD_W'(in_data) * PROD_W'(in_weight);
        term = DATA_W'(prod >> SCALE_SHIFT);
    end

endmodule

// File: rtl/neuron_sequencer.sv
// Sequences one neuron evaluation: accumulate N_INPUTS saturating terms, then compare to threshold.
module neuron_sequencer
    import neuron_pkg::*;
#(
    parameter int unsigned       N_INPUTS   = 4,
    parameter logic [DATA_W-1:0] THRESH_DEF = 32'd100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                thresh_wr,
    input  logic [DATA_W-1:0]   thresh_in,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [WEIGHT_W-1:0] in_weight,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   sum,
    output logic                fire,
    output logic                ovf
);

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(N_INPUTS - 1);

    state_e            state;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] thresh;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_acc;
    logic [DATA_W-1:0] term_val;
    sat_sum_t          add_res;

    neuron_term u_term (
        .in_data   (in_data),
        .in_weight (in_weight),
        .term      (term_val)
    );

    always_comb add_res = sat_add(acc, term_val);

    // ovf_acc tracks saturation during the run; the visible ovf only moves in StAct.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            acc      <= '0;
            cnt      <= '0;
            ovf_acc  <= 1'b0;
            thresh   <= THRESH_DEF;
            sum      <= '0;
            fire     <= 1'b0;
            ovf      <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (thresh_wr) begin
                        thresh <= thresh_in;
                    end
                    if (start) begin
                        state    <= StAccum;
                        acc      <= '0;
                        cnt      <= '0;
                        ovf_acc  <= 1'b0;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                    end
                end
                StAccum: begin
                    if (in_valid && in_ready) begin
                        acc <= add_res.value;
                        cnt <= cnt + 8'd1;
                        if (add_res.sat) begin
                            ovf_acc <= 1'b1;
                        end
                        if (cnt == LastIdx) begin
                            state    <= StAct;
                            in_ready <= 1'b0;
                        end
                    end
                end
                StAct: begin
                    sum   <= acc;
                    fire  <= (acc >= thresh);
                    ovf   <= ovf_acc;
                    state <= StDone;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed and randomized evaluations checked against an arithmetic model of the neuron.
module tb_neuron_sequencer;

    localparam int          N      = 4;
    localparam logic [31:0] TH_DEF = 32'd100;

    logic        clk = 1'b0;
    logic        rst, start, thresh_wr, in_valid, in_ready, busy, done, fire, ovf;
    logic [31:0] thresh_in, in_data, sum;
    logic [3:0]  in_weight;

    int          n_asserts = 0;
    int          n_fails   = 0;

    logic [31:0] th_m      = TH_DEF;
    logic [31:0] prev_sum  = '0;
    logic        prev_fire = 1'b0;
    logic        prev_ovf  = 1'b0;
    logic [31:0] td[N];
    logic [3:0]  tw[N];

    always #5 clk = ~clk;

    neuron_sequencer #(
        .N_INPUTS   (N),
        .THRESH_DEF (TH_DEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .thresh_wr (thresh_wr),
        .thresh_in (thresh_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_weight (in_weight),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .fire      (fire),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: scaled products summed in 64 bits, clamped to 32 bits after every add.
    function automatic void model(output logic [31:0] s_o, output logic ovf_o);
        logic [63:0] s;
        s     = '0;
        ovf_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            s = s + (((64'(td[k]) * 64'(tw[k])) / 64'd4) & 64'hFFFF_FFFF);
            if (s > 64'hFFFF_FFFF) begin
                s     = 64'hFFFF_FFFF;
                ovf_o = 1'b1;
            end
        end
        s_o = s[31:0];
    endfunction

    task automatic write_th(input logic [31:0] v);
        @(negedge clk);
        thresh_wr = 1'b1;
        thresh_in = v;
        @(negedge clk);
        thresh_wr = 1'b0;
        th_m      = v;
    endtask

    task automatic run_eval(input string tag, input bit gap, input bit mid_pulse, input bit wr,
                            input logic [31:0] wr_val, input bit start_in_done);
        logic [31:0] exp_sum;
        logic        exp_ovf, exp_fire;
        int          last, done_c, k;
        if (wr) th_m = wr_val;
        model(exp_sum, exp_ovf);
        exp_fire = (exp_sum >= th_m);
        last     = gap ? 2 * N - 1 : N;
        done_c   = last + 2;
        k        = 0;
        @(negedge clk);
        chk({tag, ".idle_busy"}, 32'(busy), 0);
        chk({tag, ".idle_ready"}, 32'(in_ready), 0);
        chk({tag, ".idle_done"}, 32'(done), 0);
        start     = 1'b1;
        thresh_wr = wr;
        thresh_in = wr_val;
        in_valid  = 1'b0;
        for (int i = 1; i <= done_c; i++) begin
            @(negedge clk);
            start     = 1'b0;
            thresh_wr = 1'b0;
            thresh_in = $urandom;
            in_valid  = 1'b0;
            in_data   = $urandom;
            in_weight = 4'($urandom);
            chk($sformatf("%s.ready@%0d", tag, i), 32'(in_ready), 32'(i <= last));
            chk($sformatf("%s.busy@%0d", tag, i), 32'(busy), 32'(i <= last + 1));
            chk($sformatf("%s.done@%0d", tag, i), 32'(done), 32'(i == done_c));
            if (i <= last + 1) begin
                chk($sformatf("%s.hold_sum@%0d", tag, i), sum, prev_sum);
                chk($sformatf("%s.hold_fire@%0d", tag, i), 32'(fire), 32'(prev_fire));
                chk($sformatf("%s.hold_ovf@%0d", tag, i), 32'(ovf), 32'(prev_ovf));
            end
            if (i <= last && (!gap || (i % 2 == 1))) begin
                in_valid  = 1'b1;
                in_data   = td[k];
                in_weight = tw[k];
                k++;
            end else if (i > last) begin
                in_valid = 1'b1;  // nothing may be accepted once in_ready has dropped
            end
            if (mid_pulse && i == 2) begin
                start     = 1'b1;
                thresh_wr = 1'b1;
                thresh_in = 32'd1000;
            end
            if (i == done_c) begin
                chk({tag, ".sum"}, sum, exp_sum);
                chk({tag, ".fire"}, 32'(fire), 32'(exp_fire));
                chk({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
                start = start_in_done;
            end
        end
        prev_sum  = exp_sum;
        prev_fire = exp_fire;
        prev_ovf  = exp_ovf;
    endtask

    initial begin
        logic [31:0] thr;
        rst       = 1'b1;
        start     = 1'b0;
        thresh_wr = 1'b0;
        thresh_in = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_weight = '0;
        repeat (2) @(negedge clk);
        chk("rst.sum", sum, 0);
        chk("rst.fire", 32'(fire), 0);
        chk("rst.ovf", 32'(ovf), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.ready", 32'(in_ready), 0);
        rst = 1'b0;

        td = '{32'd40, 32'd40, 32'd8, 32'd0};
        tw = '{4'd4, 4'd4, 4'd2, 4'd15};
        run_eval("basic", 0, 0, 0, 0, 0);
        write_th(32'd84);
        run_eval("eq_fire", 0, 0, 0, 0, 0);

        td = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tw = '{4'd15, 4'd15, 4'd15, 4'd15};
        run_eval("sat", 0, 0, 0, 0, 0);

        td = '{32'd40, 32'd40, 32'd8, 32'd0};
        tw = '{4'd4, 4'd4, 4'd2, 4'd15};
        run_eval("gap", 1, 1, 0, 0, 0);
        run_eval("done_start", 0, 0, 0, 0, 1);
        run_eval("after_done", 0, 0, 0, 0, 0);

        // Abort after two accepted terms; a saturating term is presented during reset.
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        in_valid  = 1'b1;
        in_data   = td[0];
        in_weight = tw[0];
        @(negedge clk);
        in_data   = td[1];
        in_weight = tw[1];
        @(negedge clk);
        rst       = 1'b1;
        in_data   = 32'hFFFF_FFFF;
        in_weight = 4'hF;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("abort.sum", sum, 0);
        chk("abort.fire", 32'(fire), 0);
        chk("abort.ovf", 32'(ovf), 0);
        chk("abort.busy", 32'(busy), 0);
        chk("abort.ready", 32'(in_ready), 0);
        chk("abort.done", 32'(done), 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("abort.no_done@%0d", c), 32'(done), 0);
            chk($sformatf("abort.idle@%0d", c), 32'(busy), 0);
        end
        th_m      = TH_DEF;
        prev_sum  = '0;
        prev_fire = 1'b0;
        prev_ovf  = 1'b0;

        td = '{32'd99, 32'd0, 32'd0, 32'd0};
        tw = '{4'd4, 4'd0, 4'd0, 4'd0};
        run_eval("post_rst_below", 0, 0, 0, 0, 0);
        td[0] = 32'd101;
        run_eval("post_rst_above", 0, 0, 0, 0, 0);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N; k++) begin
                td[k] = (r % 2 == 1) ? $urandom : $urandom_range(0, 2000);
                tw[k] = 4'($urandom);
            end
            thr = (r % 2 == 1) ? $urandom : $urandom_range(0, 30000);
            run_eval($sformatf("rnd%0d", r), r == 3, 0, r != 5, thr, 0);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
